// File: rtl/pll_reset_sequencer.sv
// ---------------------------------------------------------------------------
// pll_reset_sequencer
//   Turns the raw PLL lock indication into the system-wide synchronous reset.
//   Reset is released only after lock has been stable for STABLE_CYCLES
//   and a further HOLD_CYCLES hold-off has passed. While running, lock must
//   read low for DROP_FILTER consecutive cycles before it counts as a loss.
//   A loss re-asserts reset and bumps a saturating debug counter.
//
// Ports
//   clock      : PLL output clock, rising edge
//   reset      : synchronous active-high external reset
//   locked     : raw PLL lock, asynchronous to clock
//   reset_out  : registered active-high system reset
//   ready      : registered, always ~reset_out
//   loss_count : saturating count of filtered lock losses seen in RUN
// ---------------------------------------------------------------------------
module pll_reset_sequencer #(
    parameter int STABLE_CYCLES = 1024,
    parameter int HOLD_CYCLES   = 16,
    parameter int DROP_FILTER   = 4,
    parameter int LOSS_WIDTH    = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  locked,
    output logic                  reset_out,
    output logic                  ready,
    output logic [LOSS_WIDTH-1:0] loss_count
);

    localparam int CNT_MAX = (STABLE_CYCLES > HOLD_CYCLES) ? STABLE_CYCLES : HOLD_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;
    localparam int DROP_W  = $clog2(DROP_FILTER) + 1;

    localparam logic [CNT_W-1:0]  STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [DROP_W-1:0] DROP_LAST   = DROP_W'(DROP_FILTER - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABILIZE = 2'd1,
        HOLD      = 2'd2,
        RUN       = 2'd3
    } state_e;

    // Power-up values match the reset values so reset_out is asserted from
    // the very first edge after configuration.
    state_e                  state_q     = WAIT_LOCK;
    state_e                  state_d;
    logic                    sync1_q     = 1'b0;
    logic                    sync2_q     = 1'b0;
    logic [CNT_W-1:0]        cnt_q       = '0;
    logic [CNT_W-1:0]        cnt_d;
    logic [DROP_W-1:0]       drop_q      = '0;
    logic [DROP_W-1:0]       drop_d;
    logic [LOSS_WIDTH-1:0]   loss_q      = '0;
    logic [LOSS_WIDTH-1:0]   loss_d;
    logic                    reset_out_q = 1'b1;
    logic                    reset_out_d;
    logic                    ready_q     = 1'b0;
    logic                    loss_event;
    logic                    locked_s;

    // Two-flop synchroniser for the asynchronous lock input.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= locked;
            sync2_q <= sync1_q;
        end
    end

    assign locked_s = sync2_q;

    // State register and counters.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= WAIT_LOCK;
            cnt_q   <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            drop_q  <= drop_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        drop_d     = drop_q;
        loss_event = 1'b0;
        unique case (state_q)
            WAIT_LOCK: begin
                if (locked_s) state_d = STABILIZE;
            end
            STABILIZE: begin
                if (!locked_s)                state_d = WAIT_LOCK;
                else if (cnt_q == STABLE_LAST) state_d = HOLD;
                else                           cnt_d   = cnt_q + CNT_W'(1);
            end
            HOLD: begin
                if (!locked_s)              state_d = WAIT_LOCK;
                else if (cnt_q == HOLD_LAST) state_d = RUN;
                else                         cnt_d   = cnt_q + CNT_W'(1);
            end
            RUN: begin
                if (locked_s) begin
                    drop_d = '0;
                end else if (drop_q == DROP_LAST) begin
                    state_d    = WAIT_LOCK;
                    loss_event = 1'b1;
                end else begin
                    drop_d = drop_q + DROP_W'(1);
                end
            end
            default: state_d = WAIT_LOCK;
        endcase
        // Every state change starts both counters from zero.
        if (state_d != state_q) begin
            cnt_d  = '0;
            drop_d = '0;
        end
    end

    // Output decode from next state, so the registered outputs line up with
    // the state they describe.
    always_comb begin
        reset_out_d = (state_d != RUN);
        loss_d      = loss_q;
        if (loss_event && (loss_q != '1)) loss_d = loss_q + LOSS_WIDTH'(1);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            reset_out_q <= 1'b1;
            ready_q     <= 1'b0;
            loss_q      <= '0;
        end else begin
            reset_out_q <= reset_out_d;
            ready_q     <= ~reset_out_d;
            loss_q      <= loss_d;
        end
    end

    assign reset_out  = reset_out_q;
    assign ready      = ready_q;
    assign loss_count = loss_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
module tb_pll_reset_sequencer;

    localparam int S  = 8;
    localparam int H  = 4;
    localparam int D  = 3;
    localparam int LW = 2;

    logic          clock;
    logic          reset;
    logic          locked;
    logic          reset_out;
    logic          ready;
    logic [LW-1:0] loss_count;

    int n_checks = 0;
    int n_err    = 0;

    pll_reset_sequencer #(
        .STABLE_CYCLES(S),
        .HOLD_CYCLES  (H),
        .DROP_FILTER  (D),
        .LOSS_WIDTH   (LW)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .locked    (locked),
        .reset_out (reset_out),
        .ready     (ready),
        .loss_count(loss_count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one edge; outputs are sampled 1 ns after it.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        locked = 1'b0;
        repeat (3) step();
        chk("rst_reset_out", reset_out, 1);
        chk("rst_ready", ready, 0);
        chk("rst_loss", loss_count, 0);
        reset = 1'b0;
    endtask

    // Next edge is edge 0 with locked=1; release expected at edge S+H+2.
    task automatic qualify(input string tag);
        locked = 1'b1;
        for (int e = 0; e <= S + H + 2; e++) begin
            step();
            if (e < S + H + 2) begin
                chk({tag, "_held"}, reset_out, 1);
            end else begin
                chk({tag, "_released"}, reset_out, 0);
                chk({tag, "_ready"}, ready, 1);
            end
        end
    endtask

    // From RUN: drop lock at edge d; reset_out rises at edge d+1+D.
    task automatic drop_lock(input string tag, input int exp_loss);
        locked = 1'b0;
        repeat (D + 1) step();
        chk({tag, "_still_run"}, reset_out, 0);
        step();
        chk({tag, "_reset"}, reset_out, 1);
        chk({tag, "_ready"}, ready, 0);
        chk({tag, "_loss"}, loss_count, exp_loss);
        repeat (2) step();
    endtask

    initial begin
        reset  = 1'b1;
        locked = 1'b0;

        // Basic qualification.
        do_reset();
        qualify("q1");
        chk("q1_loss", loss_count, 0);

        // Lock drop during STABILIZE restarts qualification.
        do_reset();
        locked = 1'b1;
        repeat (4) step();
        locked = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stab_drop_held", reset_out, 1);
        end
        qualify("q2");
        chk("q2_loss", loss_count, 0);

        // Short glitch in RUN is filtered.
        locked = 1'b0;
        repeat (2) step();
        locked = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("glitch_run", reset_out, 0);
        end
        chk("glitch_loss", loss_count, 0);

        // Qualified losses, saturating at 3.
        drop_lock("loss1", 1);
        for (int n = 2; n <= 5; n++) begin
            qualify("rq");
            drop_lock("lossN", (n > 3) ? 3 : n);
        end

        // Reset while in HOLD.
        locked = 1'b1;
        repeat (S + 4) step();
        chk("hold_pre", reset_out, 1);
        reset = 1'b1;
        step();
        chk("hold_rst_reset_out", reset_out, 1);
        chk("hold_rst_ready", ready, 0);
        chk("hold_rst_loss", loss_count, 0);
        reset = 1'b0;
        qualify("q3");

        // Reset while in RUN with a nonzero loss count.
        drop_lock("loss_pre", 1);
        qualify("q4");
        reset = 1'b1;
        step();
        chk("run_rst_reset_out", reset_out, 1);
        chk("run_rst_ready", ready, 0);
        chk("run_rst_loss", loss_count, 0);
        reset = 1'b0;
        qualify("q5");

        // Lock toggling every cycle never qualifies.
        do_reset();
        for (int i = 0; i < 100; i++) begin
            locked = i[0];
            step();
            chk("toggle_reset_out", reset_out, 1);
            chk("toggle_ready", ready, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
